// File: rtl/mem_stage_pkg.sv
// Shared processor definitions for the memory stage: FSM encoding and the
// default timing/geometry parameters of the data memory.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam int          DEF_WAIT_CYCLES = 5;
   localparam int          DEF_DEPTH_WORDS = 64;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read through a
// single word-index port.
module data_memory #(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // NOTE: the array has no reset; its contents must survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// Multi-cycle memory stage: captures a load/store, waits WAIT_CYCLES access
// cycles while stalling the pipeline, then performs it against data_memory.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_R_en,
   input  logic        mem_W_en,
   input  logic [31:0] alu_result,
   input  logic [31:0] val_rm,
   output logic [31:0] mem_read_value,
   output logic        ready,
   output logic        addr_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   mem_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;
   logic             store_q;

   logic             req;
   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] word_idx;
   logic             last_access;
   logic             we;
   logic [31:0]      rdata;

   assign req         = mem_R_en | mem_W_en;
   assign offset      = addr_q - BASE_ADDR;
   assign in_range    = (addr_q >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));
   assign word_idx    = offset[IDX_W+1:2];
   assign last_access = (state == ACCESS) && (cnt == '0);
   // Gating on state means an asynchronous reset mid-store drops the write.
   assign we          = last_access && store_q && in_range;

   data_memory #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_data_memory (
      .clk  (clk),
      .we   (we),
      .idx  (word_idx),
      .wdata(data_q),
      .rdata(rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: default assignment first keeps this purely combinational (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      case (state)
         IDLE:    ready = ~req;
         DONE:    ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt            <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         store_q        <= 1'b0;
         mem_read_value <= '0;
         addr_err       <= 1'b0;
      end else begin
         addr_err <= last_access && !in_range;
         case (state)
            IDLE: begin
               if (req) begin
                  addr_q  <= alu_result;
                  data_q  <= val_rm;
                  store_q <= mem_W_en;
                  cnt     <= CNT_W'(WAIT_CYCLES - 1);
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!store_q) begin
                  mem_read_value <= in_range ? rdata : 32'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a word-array model;
// a second instance runs with WAIT_CYCLES = 1 for the back-to-back case.
module tb_mem_stage;

   localparam int WC0 = 5;
   localparam int WC1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_en [2];
   logic        w_en [2];
   logic [31:0] addr [2];
   logic [31:0] wdat [2];
   logic [31:0] rv   [2];
   logic        rdy  [2];
   logic        aerr [2];

   int          checks   = 0;
   int          failures = 0;

   logic [31:0] mdl_mem   [2][64];
   bit          mdl_ok    [2][64];
   logic [31:0] mdl_rv    [2];
   bit          rv_known  [2];

   always #5 clk = ~clk;

   mem_stage #(.WAIT_CYCLES(WC0)) dut0 (
      .clk(clk), .rst(rst), .mem_R_en(r_en[0]), .mem_W_en(w_en[0]),
      .alu_result(addr[0]), .val_rm(wdat[0]), .mem_read_value(rv[0]),
      .ready(rdy[0]), .addr_err(aerr[0])
   );

   mem_stage #(.WAIT_CYCLES(WC1)) dut1 (
      .clk(clk), .rst(rst), .mem_R_en(r_en[1]), .mem_W_en(w_en[1]),
      .alu_result(addr[1]), .val_rm(wdat[1]), .mem_read_value(rv[1]),
      .ready(rdy[1]), .addr_err(aerr[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int wait_of(input int s);
      return (s == 0) ? WC0 : WC1;
   endfunction

   // One complete access on instance s, checked against the word-array model.
   task automatic do_access(input int s, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d);
      int low;
      bit inr;
      int idx;
      inr = (a >= 32'd1024) && (((a - 32'd1024) >> 2) < 32'd64);
      idx = inr ? int'((a - 32'd1024) >> 2) : 0;
      @(negedge clk);
      r_en[s] = rd; w_en[s] = wr; addr[s] = a; wdat[s] = d;
      #1 check("req_ready_low", 32'(rdy[s]), 32'd0);
      low = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rdy[s]) break;
         low++;
         if (wr && rv_known[s]) check("store_hold_rv", rv[s], mdl_rv[s]);
      end
      r_en[s] = 1'b0; w_en[s] = 1'b0;
      check("access_cycles", 32'(low), 32'(wait_of(s)));
      if (wr) begin
         if (inr) begin
            mdl_mem[s][idx] = d;
            mdl_ok[s][idx]  = 1'b1;
         end
      end else begin
         mdl_rv[s]   = inr ? mdl_mem[s][idx] : 32'd0;
         rv_known[s] = !inr || mdl_ok[s][idx];
      end
      check("addr_err_done", 32'(aerr[s]), 32'(!inr));
      if (rv_known[s]) check("read_value", rv[s], mdl_rv[s]);
      @(negedge clk);
      check("addr_err_pulse", 32'(aerr[s]), 32'd0);
      check("idle_ready", 32'(rdy[s]), 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      bit          rd, wr;
      bit          seq [$];
      int          dones;
      logic [3:0]  packed_seq;

      for (int s = 0; s < 2; s++) begin
         r_en[s] = 1'b0; w_en[s] = 1'b0; addr[s] = '0; wdat[s] = '0;
         mdl_rv[s] = '0; rv_known[s] = 1'b1;
         for (int i = 0; i < 64; i++) begin
            mdl_mem[s][i] = '0; mdl_ok[s][i] = 1'b0;
         end
      end

      #1;
      for (int s = 0; s < 2; s++) begin
         check("rst_ready", 32'(rdy[s]), 32'd1);
         check("rst_rv", rv[s], 32'd0);
         check("rst_err", 32'(aerr[s]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed scenarios.
      do_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
      do_access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
      do_access(0, 1'b1, 1'b0, 32'd1031, 32'h0);
      do_access(0, 1'b0, 1'b1, 32'd1020, 32'hBAD0BAD0);
      do_access(0, 1'b1, 1'b0, 32'd1024 + 32'd256, 32'h0);
      do_access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
      do_access(0, 1'b1, 1'b1, 32'd1032, 32'h5);
      do_access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
      do_access(0, 1'b0, 1'b1, 32'd1276, 32'hA5A5_0001);
      do_access(0, 1'b1, 1'b0, 32'd1279, 32'h0);

      // Reset during the third access cycle of a store must not write.
      do_access(0, 1'b0, 1'b1, 32'd1036, 32'hCAFE_0001);
      @(negedge clk);
      r_en[0] = 1'b0; w_en[0] = 1'b1; addr[0] = 32'd1036; wdat[0] = 32'h1234;
      repeat (3) @(negedge clk);
      rst = 1'b1; w_en[0] = 1'b0;
      #1;
      check("midrst_ready", 32'(rdy[0]), 32'd1);
      check("midrst_rv", rv[0], 32'd0);
      check("midrst_err", 32'(aerr[0]), 32'd0);
      mdl_rv[0] = '0; mdl_rv[1] = '0;
      rv_known[0] = 1'b1; rv_known[1] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_access(0, 1'b1, 1'b0, 32'd1036, 32'h0);

      // Randomized traffic around both range boundaries.
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 9);
         if (k == 9) a = 32'd1280 + 32'($urandom_range(0, 20));
         else        a = 32'd1020 + 32'(4 * k) + 32'($urandom_range(0, 3));
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         do_access(0, rd, wr, a, $urandom);
      end

      // Back-to-back loads on the single-wait-cycle instance.
      do_access(1, 1'b0, 1'b1, 32'd1024, 32'h1111_1111);
      do_access(1, 1'b0, 1'b1, 32'd1028, 32'h2222_2222);
      @(negedge clk);
      r_en[1] = 1'b1; addr[1] = 32'd1024;
      #1 seq.push_back(rdy[1]);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (seq[$] != rdy[1]) seq.push_back(rdy[1]);
         if (rdy[1]) begin
            dones++;
            if (dones == 1) begin
               check("b2b_first", rv[1], 32'h1111_1111);
               addr[1] = 32'd1028;
            end else begin
               check("b2b_second", rv[1], 32'h2222_2222);
               r_en[1] = 1'b0;
               break;
            end
         end
      end
      check("b2b_dones", 32'(dones), 32'd2);
      packed_seq = '0;
      foreach (seq[i]) if (i < 4) packed_seq[3-i] = seq[i];
      check("b2b_len", 32'(seq.size()), 32'd4);
      check("b2b_seq", 32'(packed_seq), 32'b0101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WAIT_CYCLES, default 5, SHALL set the number of access cycles per memory operation; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit data-memory words.
REQ-003 Parameter BASE_ADDR, default 1024, SHALL set the byte address that maps to word 0.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 mem_R_en  input  1  load request from the EX/MEM register.
REQ-007 mem_W_en  input  1  store request from the EX/MEM register.
REQ-008 alu_result  input  32  byte address computed by EX.
REQ-009 val_rm  input  32  store data.
REQ-010 mem_read_value  output  32  load data, registered.
REQ-011 ready  output  1  high = the pipeline may advance; low = upstream stages SHALL freeze.
REQ-012 addr_err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-014 In IDLE with mem_R_en or mem_W_en high, the next state SHALL be ACCESS; address, data and operation are captured and the wait counter is loaded with WAIT_CYCLES-1.
REQ-015 In ACCESS, the counter SHALL decrement each cycle; when it is zero, the operation is performed and the next state SHALL be DONE.
REQ-016 DONE SHALL last exactly one cycle, after which the next state SHALL be IDLE; the request lines are ignored in DONE.
REQ-017 ready SHALL be combinational: high in IDLE with no request, or in DONE; low otherwise.
REQ-018 Latency: with a request first seen in cycle 0, ready SHALL rise in cycle WAIT_CYCLES+1.
REQ-019 The word index SHALL be (address - BASE_ADDR) >> 2; address bits [1:0] are ignored.
REQ-020 An index of DEPTH_WORDS or more, or an address below BASE_ADDR, is out of range: a write SHALL be suppressed, a read SHALL return 0, and addr_err SHALL pulse in the DONE cycle.
REQ-021 A store SHALL write the captured val_rm in the final ACCESS cycle; the write SHALL be visible to any later load.
REQ-022 A load SHALL register the word into mem_read_value in the final ACCESS cycle, so it is valid in DONE; the value is held until the next load completes.
REQ-023 If mem_R_en and mem_W_en are both high, the access SHALL be treated as a store.
REQ-024 A store SHALL NOT change mem_read_value.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, mem_read_value 0 and addr_err 0 immediately, including mid-ACCESS.
REQ-026 A store in progress when rst asserts SHALL NOT write memory.
REQ-027 Memory contents SHALL be unaffected by reset.

Structure
REQ-028 The FSM state encoding and the default values of WAIT_CYCLES, DEPTH_WORDS and BASE_ADDR SHALL reside in the shared processor package.
REQ-029 The storage array SHALL be a sub-module, data_memory, with a synchronous write, a combinational read and a word-index port; the FSM and the counter stay in mem_stage.

Verification
REQ-030 Store 0xDEADBEEF to address 1028, then load from 1028 -> ready is low for 5 cycles on each access and mem_read_value = 0xDEADBEEF in the DONE cycle of the load.
REQ-031 Load from address 1031 after the store of REQ-030 -> the same word 0xDEADBEEF is returned (low bits ignored).
REQ-032 Store to address 1020, then load from 1024+4*64 -> addr_err pulses once per access, memory is unchanged and the load returns 0.
REQ-033 Assert mem_R_en and mem_W_en together with val_rm = 0x5 at address 1032, then load from 1032 -> 0x5 is read and mem_read_value is unchanged during the combined access.
REQ-034 Assert rst during the third ACCESS cycle of a store of 0x1234 to address 1036 -> the state returns to IDLE with ready high, and a later load from 1036 returns the old contents.
REQ-035 Two back-to-back loads with WAIT_CYCLES = 1 -> ready follows the sequence 0,1,0,1, with no request lost.
